// File: rtl/tick_gen_if.sv
// tick_gen_if: bundles the controls (en, clr, div) and outputs (tick, sq) of tick_gen.
// The master drives the controls and observes the outputs. The slave is the generator itself.
interface tick_gen_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
);
  logic                 en;
  logic                 clr;
  logic [NCH*WIDTH-1:0] div;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       sq;

  modport master (
    output en,
    output clr,
    output div,
    input  tick,
    input  sq
  );

  modport slave (
    input  en,
    input  clr,
    input  div,
    output tick,
    output sq
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: NCH independent programmable tick generators.
// Each channel counts 0..D and then wraps, giving a period of D+1 steps.
// On each wrap the channel emits a one-cycle tick pulse, toggles its square wave,
// and loads the next divisor from its div slice.
// The divisor in use is latched only at a wrap or at clr. A div change in the
// middle of a period therefore never shortens the current period, and cnt never
// exceeds the active divisor.
// Optional feature: when TICK_GEN_CASCADE_EN is defined, channel i>0 advances only
// on cycles where tick[i-1] is high. The periods then multiply down the chain.
module tick_gen #(
  parameter int WIDTH       = 8,
  parameter int NCH         = 2,
  parameter int DEFAULT_DIV = 128
) (
  input logic       clk,
  input logic       rst_n,
  tick_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] act_q [NCH];
  logic [NCH-1:0]   tick_q;
  logic [NCH-1:0]   sq_q;
  logic [NCH-1:0]   step;
  logic             run;

  assign run = bus.en & ~bus.clr;

  // Work out which channels advance this cycle. Channel 0 always follows run.
  always_comb begin
    step    = '0;
    step[0] = run;
    for (int i = 1; i < NCH; i++) begin
`ifdef TICK_GEN_CASCADE_EN
      step[i] = run & tick_q[i-1];
`else
      step[i] = run;
`endif
    end
  end

  // Per-channel counter, active divisor, tick pulse and square wave. clr overrides en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_DIV;
      end
      tick_q <= '0;
      sq_q   <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= bus.div[i*WIDTH +: WIDTH];
      end
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        tick_q[i] <= 1'b0;
        if (step[i]) begin
          if (cnt_q[i] == act_q[i]) begin
            cnt_q[i]  <= '0;
            tick_q[i] <= 1'b1;
            sq_q[i]   <= ~sq_q[i];
            act_q[i]  <= bus.div[i*WIDTH +: WIDTH];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.tick = tick_q;
  assign bus.sq   = sq_q;

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter WIDTH, default 8: divisor/counter width in bits, 2..32.
REQ-002 Parameter NCH, default 2: number of independent tick channels, 1..8.
REQ-003 Parameter DEFAULT_DIV, default 128: active divisor of every channel after reset; must fit in WIDTH bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  global count enable; low freezes all counters.
REQ-007 clr  input  1  synchronous clear of all channels.
REQ-008 div  input  NCH*WIDTH  requested divisor per channel; channel i uses bits [i*WIDTH +: WIDTH].
REQ-009 tick  output  NCH  registered one-cycle enable pulse per channel.
REQ-010 sq  output  NCH  registered square wave per channel; toggles on each tick.

Function
REQ-011 Each channel i has a WIDTH-bit counter cnt[i] and a WIDTH-bit active divisor act[i]; Di = act[i].
REQ-012 A channel "steps" in a cycle when en=1 and clr=0 and (channel 0, or TICK_GEN_CASCADE_EN undefined, or tick[i-1]=1).
REQ-013 On a step with cnt[i] != Di: cnt[i] increments by 1, tick[i] is 0 in the next cycle.
REQ-014 On a step with cnt[i] == Di (wrap): cnt[i] becomes 0, tick[i] is 1 in the next cycle, sq[i] inverts, act[i] loads div slice i.
REQ-015 Cycles with no step: cnt[i], act[i] and sq[i] hold; tick[i] is 0 in the next cycle.
REQ-016 Tick period with continuous steps: exactly Di+1 steps; tick high for exactly one clk cycle per period.
REQ-017 Di = 0: every step is a wrap; with continuous steps tick[i] stays high and sq[i] toggles every cycle.
REQ-018 Changing div mid-period has no effect until the next wrap of that channel; the current period completes with the old Di.
REQ-019 Because act[i] changes only at wrap or clr, cnt[i] never exceeds Di; no lock-up state exists.
REQ-020 clr=1 (priority over en): all cnt to 0, all tick to 0, all sq to 0, all act load their div slices, next cycle.
REQ-021 en falling mid-period: counters freeze at current value; counting resumes from that value when en returns high; no tick generated while en=0.
REQ-022 Channels are independent except as stated in REQ-012; simultaneous wraps on several channels are all honoured in the same cycle.
REQ-023 Latency: tick[i] and sq[i] change in the cycle after the wrapping step; no combinational path from any input to tick or sq.

Reset
REQ-024 rst_n low asynchronously forces: all cnt = 0, all act = DEFAULT_DIV, tick = 0, sq = 0.
REQ-025 Deassertion of rst_n is sampled on clk; first step can occur in the first cycle after rst_n is seen high.
REQ-026 Reset asserted mid-period discards the period; no tick emitted from a partial count.

Configuration
REQ-027 Macro TICK_GEN_CASCADE_EN defined: channel i>0 steps only on cycles where tick[i-1]=1 (and en=1, clr=0), giving period product (D0+1)*...*(Di+1) clk cycles.
REQ-028 Macro TICK_GEN_CASCADE_EN undefined: every channel steps on every cycle with en=1 and clr=0; no inter-channel dependency logic is present.

Verification
REQ-029 WIDTH=8, NCH=2, reset release, en=1, div unchanged -> tick[0] first high 129 cycles after first step, then every 129 cycles, one cycle wide; sq[0] toggles at each tick.
REQ-030 div slice 0 changed from 128 to 3 at cnt=50 -> current period still 129 cycles, subsequent periods 4 cycles.
REQ-031 div slice 1 = 0, en=1 -> tick[1] held high continuously; sq[1] toggles every cycle.
REQ-032 en dropped at cnt[0]=10 for 20 cycles -> no ticks during gap; next tick 119 steps after en returns; clr pulse anywhere -> tick=0, sq=0, next tick after Di+1 steps.
REQ-033 rst_n pulled low asynchronously between clk edges mid-period -> tick, sq, counters clear immediately without waiting for clk; act returns to 128.
REQ-034 TICK_GEN_CASCADE_EN defined, div0=3, div1=4 -> tick[0] every 4 cycles, tick[1] every 20 cycles; undefined -> tick[1] every 5 cycles.
